muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
// - Iterative MIPS multiply/divide unit with architectural HI/LO registers, one stage downstream of the register file.
// - Consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// - Exposes HI/LO to the writeback mux for MFHI/MFLO.
// - Raises busy so the pipeline control can stall dependent MFHI/MFLO and new mul/div ops.
// PARAMETERS
// - WIDTH   32  operand width; HI/LO are WIDTH each, product is 2*WIDTH
// - CNT_W    6  iteration counter width; must hold WIDTH
// PORTS
// - clk     in   1      clock, rising edge
// - reset   in   1      asynchronous, active-low
// - start   in   1      request; sampled on the rising clk edge
// - op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others: no-op
// - flush   in   1      synchronous cancel of an in-flight mul/div (exception/branch squash)
// - rs_data in   WIDTH  operand A / dividend / MTHI-MTLO source
// - rt_data in   WIDTH  operand B / divisor
// - busy    out  1      high while a mul/div is in flight
// - done    out  1      one-cycle pulse in the cycle after HI/LO update from mul/div
// - hi      out  WIDTH  HI register
// - lo      out  WIDTH  LO register
// BEHAVIOUR
// - Reset (async, reset=0): state=IDLE; hi=lo=0, busy=0, done=0, counter=0. Holds regardless of clk.
// - FSM states:
//   - IDLE: start & mul/div op -> latch |rs|,|rt| (unsigned ops: raw values), record the result signs, cnt=0 -> CALC.
//   - CALC: one radix-2 step per edge (shift-add multiply / restoring divide); after WIDTH steps -> FIX.
//   - FIX: apply signs, write HI/LO, done=1 for exactly one cycle -> IDLE.
// - Latency: start edge E0; busy=1 after E0; CALC occupies E1..E32; HI/LO written and busy=0 after E33.
//   - Total 33 cycles for WIDTH=32, identical for all mul/div ops and operand values.
// - MTHI/MTLO: when not busy, start writes rs_data to hi/lo at that edge. No busy, no done.
// - start while busy is ignored (no queueing); hi/lo stay stable at their previous values until the FIX edge.
// - Multiply results: {hi,lo} = 64-bit product.
//   - MULT: two's-complement signed operands.
//   - MULTU: unsigned operands.
// - Divide results: lo = quotient, hi = remainder.
//   - DIV: quotient sign = sign(rs)^sign(rt); remainder takes the sign of rs; quotient truncates toward zero.
//   - DIVU: unsigned operands.
// - Boundary cases:
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
//   - Divide by zero (DIV and DIVU): lo=0xFFFFFFFF, hi=rs_data. Still takes full latency.
// - flush=1 in CALC or FIX: return to IDLE next edge; busy=0; hi/lo unchanged; no done.
//   - flush in IDLE has no effect; flush overrides a simultaneous start.
// - Reset mid-operation: async abort to reset values; no done.
// - done and busy are never high in the same cycle.
// STRUCTURE
// - Shared header muldiv_defs.vh:
//   - op encodings OP_MULT..OP_MTLO
//   - state encodings S_IDLE/S_CALC/S_FIX
// - The same op encodings are used by the control unit decoder.
// - One sub-module, muldiv_step: combinational single iteration.
//   - Inputs: mode, partial remainder/product, operand; outputs: next partial value and quotient bit.
//   - muldiv_unit owns the FSM, counter, sign fix-up and the HI/LO registers.
// TESTING
// - MULT rs=0xFFFFFFFE (-2), rt=3 -> busy for 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once.
// - MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
// - DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
// - DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
// - DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234, after 33 cycles.
// - Mid-op and idle events:
//   - MTHI 0xA5A5A5A5 while idle -> hi updates next edge.
//   - New start during DIV -> ignored.
//   - flush at cycle 10 -> busy drops, hi/lo keep their pre-op values.
//   - reset low at cycle 20 -> hi=lo=0 immediately.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// The op encodings are also used by the control-unit decoder, so keep them
// in sync with it. The file also holds the FSM state encoding and small
// decode helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // The iterative ops are exactly the encodings with op[2] clear.
    function automatic logic is_muldiv_op(input logic [2:0] op_v);
        return (op_v[2] == 1'b0);
    endfunction

    // MULT and DIV (even encodings) treat the operands as two's complement.
    function automatic logic is_signed_op(input logic [2:0] op_v);
        return (op_v[0] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Combinational single radix-2 iteration for the multiply/divide unit.
// Ports:
//   mode_div  1        1: restoring divide step, 0: shift-add multiply step
//   part_in   2*W+1    partial product, or {remainder, dividend/quotient}
//   operand   W        multiplicand or divisor magnitude
//   part_out  2*W+1    next partial value (divide: LSB left clear)
//   q_bit     1        quotient bit produced by a divide step (0 for multiply)
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode_div,
    input  logic [2*WIDTH:0]   part_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH:0]   part_out,
    output logic               q_bit
);

    logic [WIDTH:0]   sum_s;
    logic [2*WIDTH:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // One iteration. Multiply adds into the upper half and shifts right.
    // Divide shifts left and keeps the trial subtraction when it does not
    // borrow.
    always_comb begin
        sum_s     = {(WIDTH+1){1'b0}};
        shifted_s = {part_in[2*WIDTH-1:0], 1'b0};
        diff_s    = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, operand};
        part_out  = part_in;
        q_bit     = 1'b0;
        if (mode_div) begin
            if (diff_s[WIDTH+1] == 1'b0) begin
                part_out = {diff_s[WIDTH:0], shifted_s[WIDTH-1:0]};
                q_bit    = 1'b1;
            end else begin
                part_out = shifted_s;
            end
        end else begin
            sum_s    = part_in[2*WIDTH:WIDTH]
                     + (part_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
            part_out = {1'b0, sum_s, part_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with the architectural HI/LO registers.
// It runs on operand magnitudes for WIDTH steps and then applies the signs.
// Every mul/div takes WIDTH+1 cycles from the start edge to the HI/LO write.
// Ports:
//   clk, reset      clock (rising edge) and asynchronous active-low reset
//   start, op       request and operation (see muldiv_unit_pkg encodings)
//   flush           synchronous cancel of an in-flight mul/div
//   rs_data/rt_data register-file operands
//   busy            mul/div in flight
//   done            one-cycle pulse after HI/LO are written by a mul/div
//   hi, lo          HI/LO registers
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH:0]   part_r, step_part_s;
    logic [WIDTH-1:0]   opnd_r, hi_r, lo_r;
    logic               is_div_r, neg_lo_r, neg_hi_r, busy_r, done_r;
    logic               q_bit_s, op_signed_s, last_step_s, rt_nz_s;
    logic [WIDTH-1:0]   rs_abs_s, rt_abs_s, hi_fix_s, lo_fix_s;
    logic [2*WIDTH-1:0] prod_s;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (is_div_r),
        .part_in  (part_r),
        .operand  (opnd_r),
        .part_out (step_part_s),
        .q_bit    (q_bit_s)
    );

    // Operand magnitudes and decode of the incoming request.
    always_comb begin
        op_signed_s = is_signed_op(op);
        rt_nz_s     = (rt_data != {WIDTH{1'b0}});
        rs_abs_s    = (op_signed_s && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        rt_abs_s    = (op_signed_s && rt_data[WIDTH-1]) ? -rt_data : rt_data;
        last_step_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state logic. Flush wins over start and cancels CALC/FIX.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && is_muldiv_op(op) && !flush) begin
                    state_s = S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_s = S_IDLE;
                end else if (last_step_s) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Sign fix-up of the finished magnitude result.
    always_comb begin
        prod_s   = neg_lo_r ? -part_r[2*WIDTH-1:0] : part_r[2*WIDTH-1:0];
        hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
        lo_fix_s = prod_s[WIDTH-1:0];
        if (is_div_r) begin
            lo_fix_s = neg_lo_r ? -part_r[WIDTH-1:0] : part_r[WIDTH-1:0];
            hi_fix_s = neg_hi_r ? -part_r[2*WIDTH-1:WIDTH] : part_r[2*WIDTH-1:WIDTH];
        end else begin
            lo_fix_s = prod_s[WIDTH-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Iteration datapath: operand capture on launch, one step per CALC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            part_r   <= {(2*WIDTH+1){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
        end else if (state_r == S_IDLE && state_s == S_CALC) begin
            cnt_r    <= {CNT_W{1'b0}};
            part_r   <= {{(WIDTH+1){1'b0}}, rs_abs_s};
            opnd_r   <= rt_abs_s;
            is_div_r <= op[1];
            // A zero divisor yields an all-ones quotient regardless of signs.
            neg_lo_r <= op_signed_s && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1])
                        && (!op[1] || rt_nz_s);
            neg_hi_r <= op_signed_s && op[1] && rs_data[WIDTH-1];
        end else if (state_r == S_CALC) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            part_r   <= {step_part_s[2*WIDTH:1], step_part_s[0] | q_bit_s};
        end else begin
            cnt_r    <= cnt_r;
            part_r   <= part_r;
        end
    end

    // Architectural HI/LO plus the registered busy/done flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= (state_r == S_FIX) && !flush;
            if (state_r == S_FIX && !flush) begin
                hi_r <= hi_fix_s;
                lo_r <= lo_fix_s;
            end else if (state_r == S_IDLE && start && !flush && op == OP_MTHI) begin
                hi_r <= rs_data;
            end else if (state_r == S_IDLE && start && !flush && op == OP_MTLO) begin
                lo_r <= rs_data;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO values are computed by a
// reference model and queued when an op is issued. They are popped and
// compared when done pulses.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic        flush = 1'b0;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        busy, done;
    logic [31:0] hi, lo;

    exp_t        sb_q[$];
    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;
    int          n_tests = 0;
    int          n_fail = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .flush   (flush),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa, sb;
        h = 32'h0;
        l = 32'h0;
        case (o)
            OP_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {h, l} = sp;
            end
            OP_MULTU: begin
                up = {32'h0, a} * {32'h0, b};
                {h, l} = up;
            end
            OP_DIV: begin
                if (b == 32'h0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'h0;
                end else begin
                    sa = a; sb = b;
                    l = sa / sb; h = sa % sb;
                end
            end
            OP_DIVU: begin
                if (b == 32'h0) begin
                    l = 32'hFFFF_FFFF; h = a;
                end else begin
                    l = a / b; h = a % b;
                end
            end
            default: begin
                h = 32'h0; l = 32'h0;
            end
        endcase
    endfunction

    task automatic mt_op(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = v;
        @(posedge clk); #1;
        start = 1'b0;
        if (o == OP_MTHI) hi_m = v; else lo_m = v;
        check_val("mt_hi", hi, hi_m);
        check_val("mt_lo", lo, lo_m);
        check_val("mt_busy", busy, 1'b0);
        check_val("mt_done", done, 1'b0);
    endtask

    task automatic watch_no_done(input string tag);
        int dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check_val(tag, dcnt, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at, input int reset_at,
                          input bit inject);
        exp_t e;
        int   cyc, busy_cnt;
        bit   aborted = 1'b0;
        e.tag = tag;
        model(o, a, b, e.hi, e.lo);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && !aborted && cyc < 100) begin
            if (cyc == 12) begin
                check_val({tag, "_hold_hi"}, hi, hi_m);
                check_val({tag, "_hold_lo"}, lo, lo_m);
            end
            if (inject && cyc == 5) begin
                start = 1'b1; op = OP_MTHI; rs_data = 32'hDEAD_BEEF;
            end
            if (inject && cyc == 6) begin
                op = OP_MULTU; rs_data = 32'h0000_0003; rt_data = 32'h0000_0005;
            end
            if (inject && cyc == 7) start = 1'b0;
            if (flush_at == cyc) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                aborted = 1'b1;
            end else if (reset_at == cyc) begin
                reset = 1'b0;
                #1;
                hi_m = 32'h0; lo_m = 32'h0;
                check_val({tag, "_rst_hi"}, hi, 32'h0);
                check_val({tag, "_rst_lo"}, lo, 32'h0);
                check_val({tag, "_rst_busy"}, busy, 1'b0);
                aborted = 1'b1;
                @(negedge clk);
                reset = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (busy) busy_cnt++;
            end
        end
        if (aborted) begin
            void'(sb_q.pop_back());
            check_val({tag, "_abort_busy"}, busy, 1'b0);
            check_val({tag, "_abort_hi"}, hi, hi_m);
            check_val({tag, "_abort_lo"}, lo, lo_m);
            watch_no_done({tag, "_abort_nodone"});
        end else begin
            check_val({tag, "_done_seen"}, done, 1'b1);
            e = sb_q.pop_front();
            if (done) begin
                check_val({e.tag, "_hi"}, hi, e.hi);
                check_val({e.tag, "_lo"}, lo, e.lo);
                check_val({e.tag, "_latency"}, cyc - 1, 33);
                check_val({e.tag, "_busy_cycles"}, busy_cnt, 33);
                check_val({e.tag, "_busy_with_done"}, busy, 1'b0);
                hi_m = e.hi; lo_m = e.lo;
                @(posedge clk); #1;
                check_val({e.tag, "_done_pulse"}, done, 1'b0);
            end
        end
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        #3;
        check_val("rst_hi", hi, 32'h0);
        check_val("rst_lo", lo, 32'h0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        mt_op(OP_MTHI, 32'hA5A5_A5A5);
        mt_op(OP_MTLO, 32'h5A5A_5A5A);
        run_op("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 0, 0, 1'b0);
        run_op("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 1'b0);
        run_op("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
        run_op("divu_zero",  OP_DIVU,  32'h0000_1234, 32'h0000_0000, 0, 0, 1'b0);
        run_op("div_zero_n", OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 0, 0, 1'b0);
        run_op("div_inject", OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 0, 0, 1'b1);
        run_op("divu_flush", OP_DIVU,  32'h1234_5678, 32'h0000_0011, 10, 0, 1'b0);
        run_op("mult_reset", OP_MULT,  32'h0000_1111, 32'h0000_2222, 0, 20, 1'b0);
        mt_op(OP_MTHI, 32'h0BAD_F00D);
        for (int i = 0; i < 8; i++) begin
            r_op = 3'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 20));
            run_op($sformatf("rand%0d", i), r_op, r_a, r_b, 0, 0, 1'b0);
        end
        check_val("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
